// File: rtl/game_sequencer_pkg.sv
// game_sequencer_pkg: state encoding, pause lengths and car-period constants shared by the game-flow logic and car movers
package game_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_HIT       = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4
  } state_e;
  localparam int HIT_TICKS_DEF      = 30;
  localparam int LEVELUP_TICKS_DEF  = 60;
  localparam int GAMEOVER_TICKS_DEF = 120;
  localparam int MAX_LEVEL_DEF      = 9;
  localparam int BASE_PERIOD_DEF    = 24;
  localparam int PERIOD_STEP_DEF    = 2;
  localparam int MIN_PERIOD_DEF     = 6;
  // Car step period shrinks linearly with level down to a floor.
  function automatic logic [4:0] period_for(input logic [3:0] lvl, input int base, input int step, input int floor);
    int p;
    p = base - int'(lvl) * step;
    return (p < floor) ? 5'(floor) : 5'(p);
  endfunction
endpackage

// File: rtl/game_sequencer_pause.sv
// pause_timer: loadable 7-bit down-counter advanced by frame ticks; done fires on a tick seen at zero
module pause_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [6:0] load_val_i,
  input  logic       tick_i,
  output logic       done_o
);
  logic [6:0] count_q;
  // Load wins over counting; the counter parks at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else if (load_i) count_q <= load_val_i;
    else if (tick_i && count_q != '0) count_q <= count_q - 7'd1;
  end
  assign done_o = tick_i && count_q == '0;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow FSM for the frog game (respawn/level/game-over pauses); SCORE_EN adds a saturating score counter
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int HIT_TICKS      = HIT_TICKS_DEF,
  parameter int LEVELUP_TICKS  = LEVELUP_TICKS_DEF,
  parameter int GAMEOVER_TICKS = GAMEOVER_TICKS_DEF,
  parameter int MAX_LEVEL      = MAX_LEVEL_DEF,
  parameter int BASE_PERIOD    = BASE_PERIOD_DEF,
  parameter int PERIOD_STEP    = PERIOD_STEP_DEF,
  parameter int MIN_PERIOD     = MIN_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       frog_at_top,
  input  logic       collision_detected,
  input  logic [1:0] lives,
  output logic       reset_frog,
  output logic       reset_lives,
  output logic       freeze,
  output logic [3:0] level,
  output logic [4:0] car_period,
  output logic [2:0] game_state,
  output logic [9:0] score
);
  state_e     state_q, state_d;
  logic [3:0] level_q, level_d;
  logic       rf_q, rf_d, rl_q, rl_d;
  logic       start_q, coll_q, start_rise, coll_rise;
  logic       load, done;
  logic [6:0] load_val;
  assign start_rise = start_btn && !start_q;
  assign coll_rise  = collision_detected && !coll_q;
  pause_timer u_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (load),
    .load_val_i (load_val),
    .tick_i     (frame_tick),
    .done_o     (done)
  );
  // State, level and pulse registers; edge detectors keep sampling through reset so a held button cannot start a game.
  always_ff @(posedge clk) begin
    start_q <= start_btn;
    coll_q  <= collision_detected;
    if (reset) begin
      state_q <= S_IDLE;
      level_q <= '0;
      rf_q    <= 1'b0;
      rl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      rf_q    <= rf_d;
      rl_q    <= rl_d;
    end
  end
  // Next-state: transitions, pause loads, level update and respawn/lives pulses.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    rf_d     = 1'b0;
    rl_d     = 1'b0;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      S_IDLE: if (start_rise) begin
        state_d = S_PLAY;
        level_d = '0;
        rf_d    = 1'b1;
        rl_d    = 1'b1;
      end
      S_PLAY: if (coll_rise) begin
        load     = 1'b1;
        state_d  = (lives == 2'd0) ? S_GAME_OVER : S_HIT;
        load_val = (lives == 2'd0) ? 7'(GAMEOVER_TICKS) : 7'(HIT_TICKS);
      end else if (frog_at_top) begin
        load     = 1'b1;
        load_val = 7'(LEVELUP_TICKS);
        state_d  = S_LEVEL_UP;
        level_d  = (level_q == 4'(MAX_LEVEL)) ? level_q : level_q + 4'd1;
        rf_d     = 1'b1;
      end
      S_HIT, S_LEVEL_UP: if (done) begin
        state_d = S_PLAY;
        rf_d    = 1'b1;
      end
      S_GAME_OVER: if (start_rise) begin
        state_d = S_PLAY;
        level_d = '0;
        rf_d    = 1'b1;
        rl_d    = 1'b1;
      end else if (done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // Outputs: motion frozen everywhere except PLAY; period follows the registered level.
  always_comb begin
    freeze      = state_q != S_PLAY;
    game_state  = state_q;
    level       = level_q;
    car_period  = period_for(level_q, BASE_PERIOD, PERIOD_STEP, MIN_PERIOD);
    reset_frog  = rf_q;
    reset_lives = rl_q;
  end
`ifdef SCORE_EN
  logic [9:0]  score_q, score_d;
  logic [10:0] score_sum;
  // Cleared whenever lives are refilled (game start); adds the new level on each level-up, saturating.
  always_comb begin
    score_sum = {1'b0, score_q} + 11'(level_d);
    score_d   = rl_d ? '0
              : (state_q == S_PLAY && state_d == S_LEVEL_UP) ? (score_sum[10] ? 10'd1023 : score_sum[9:0])
              : score_q;
  end
  // Score register.
  always_ff @(posedge clk) begin
    if (reset) score_q <= '0;
    else score_q <= score_d;
  end
  assign score = score_q;
`else
  assign score = '0;
`endif
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed-sequence bench with randomized timing checked against a rule-level game model
module tb_game_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       frog_at_top = 1'b0;
  logic       collision_detected = 1'b0;
  logic [1:0] lives = 2'd3;
  logic       reset_frog, reset_lives, freeze;
  logic [3:0] level;
  logic [4:0] car_period;
  logic [2:0] game_state;
  logic [9:0] score;
  int total = 0;
  int bad = 0;
  int m_level, m_score, nt, np, k;
`ifdef SCORE_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  game_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .frame_tick         (frame_tick),
    .start_btn          (start_btn),
    .frog_at_top        (frog_at_top),
    .collision_detected (collision_detected),
    .lives              (lives),
    .reset_frog         (reset_frog),
    .reset_lives        (reset_lives),
    .freeze             (freeze),
    .level              (level),
    .car_period         (car_period),
    .game_state         (game_state),
    .score              (score)
  );

  always #5 clk = ~clk;

  function automatic int exp_period(input int l);
    return (24 - 2 * l < 6) ? 6 : 24 - 2 * l;
  endfunction

  function automatic int exp_score();
    return SC ? m_score : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit ft);
    frame_tick = ft;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  // Feed frame ticks with random gaps until the pause state is left; report ticks used and stray pulses.
  task automatic run_pause(input logic [2:0] st, output int ticks, output int pulses);
    ticks = 0;
    pulses = 0;
    while (game_state === st && ticks < 200) begin
      repeat ($urandom_range(2)) tick(1'b0);
      if (game_state !== st) break;
      tick(1'b1);
      ticks++;
      if (game_state === st && (reset_frog || reset_lives)) pulses++;
    end
  endtask

  task automatic level_up(input string tag);
    frog_at_top = 1'b1;
    tick(1'b0);
    frog_at_top = 1'b0;
    m_level = (m_level + 1 > 9) ? 9 : m_level + 1;
    m_score = (m_score + m_level > 1023) ? 1023 : m_score + m_level;
    chk({tag, "_state"}, game_state, 3);
    chk({tag, "_rf"}, reset_frog, 1);
    chk({tag, "_level"}, level, m_level);
    chk({tag, "_period"}, car_period, exp_period(m_level));
    chk({tag, "_score"}, score, exp_score());
    run_pause(3'd3, nt, np);
    chk({tag, "_ticks"}, nt, 61);
    chk({tag, "_exit"}, game_state, 1);
    chk({tag, "_exit_rf"}, reset_frog, 1);
  endtask

  task automatic start_game(input string tag);
    start_btn = 1'b1;
    tick(1'b0);
    m_level = 0;
    m_score = 0;
    chk({tag, "_rf"}, reset_frog, 1);
    chk({tag, "_rl"}, reset_lives, 1);
    chk({tag, "_state"}, game_state, 1);
    chk({tag, "_freeze"}, freeze, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_period"}, car_period, 24);
    chk({tag, "_score"}, score, 0);
    start_btn = 1'b0;
    tick(1'b0);
    chk({tag, "_rf_1cyc"}, reset_frog, 0);
    chk({tag, "_rl_1cyc"}, reset_lives, 0);
  endtask

  initial begin
    // Reset with start held: leaving reset must not start a game.
    start_btn = 1'b1;
    repeat (3) tick(1'b0);
    reset = 1'b0;
    repeat (3) tick(1'b0);
    chk("rst_state", game_state, 0);
    chk("rst_freeze", freeze, 1);
    chk("rst_level", level, 0);
    chk("rst_period", car_period, 24);
    chk("rst_rf", reset_frog, 0);
    chk("rst_rl", reset_lives, 0);
    chk("rst_score", score, 0);
    start_btn = 1'b0;
    tick(1'b0);
    start_game("start");

    // Collision with lives left: HIT pause of 31 frame ticks; collisions during the pause are ignored.
    lives = 2'($urandom_range(1, 3));
    collision_detected = 1'b1;
    tick(1'b0);
    collision_detected = 1'b0;
    chk("hit_state", game_state, 2);
    chk("hit_freeze", freeze, 1);
    tick(1'b0);
    collision_detected = 1'b1;
    tick(1'b0);
    collision_detected = 1'b0;
    tick(1'b0);
    chk("hit_ignore_coll", game_state, 2);
    run_pause(3'd2, nt, np);
    chk("hit_ticks", nt, 31);
    chk("hit_pulses", np, 0);
    chk("hit_exit", game_state, 1);
    chk("hit_exit_rf", reset_frog, 1);
    chk("hit_exit_freeze", freeze, 0);
    tick(1'b0);

    // Ten level-ups: level saturates at 9, period floors at 6.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(3)) tick(1'($urandom_range(1)));
      level_up($sformatf("lvl%0d", i));
    end

    // Collision and top together: collision wins, level unchanged.
    lives = 2'd1;
    collision_detected = 1'b1;
    frog_at_top = 1'b1;
    tick(1'b0);
    collision_detected = 1'b0;
    frog_at_top = 1'b0;
    chk("both_state", game_state, 2);
    chk("both_level", level, m_level);
    chk("both_rf", reset_frog, 0);
    chk("both_score", score, exp_score());
    run_pause(3'd2, nt, np);
    chk("both_ticks", nt, 31);

    // Last life lost: GAME_OVER lasts 121 ticks, returns to IDLE silently.
    tick(1'b0);
    lives = 2'd0;
    collision_detected = 1'b1;
    tick(1'b0);
    collision_detected = 1'b0;
    chk("go_state", game_state, 4);
    chk("go_freeze", freeze, 1);
    run_pause(3'd4, nt, np);
    chk("go_ticks", nt, 121);
    chk("go_pulses", np, 0);
    chk("go_exit", game_state, 0);
    chk("go_exit_rf", reset_frog, 0);
    chk("go_exit_rl", reset_lives, 0);
    chk("go_level_kept", level, m_level);

    // New game, random level-ups, then restart straight out of GAME_OVER.
    start_game("restart");
    k = $urandom_range(1, 4);
    for (int i = 0; i < k; i++) level_up($sformatf("rl%0d", i));
    lives = 2'd0;
    collision_detected = 1'b1;
    tick(1'b0);
    collision_detected = 1'b0;
    chk("go2_state", game_state, 4);
    repeat ($urandom_range(1, 20)) tick(1'b1);
    chk("go2_hold", game_state, 4);
    start_game("go_restart");

    // Reset mid LEVEL_UP aborts to IDLE without pulses; held start across reset exit does nothing.
    lives = 2'd3;
    level_up("pre_abort");
    frog_at_top = 1'b1;
    tick(1'b0);
    frog_at_top = 1'b0;
    chk("abort_pre_state", game_state, 3);
    repeat ($urandom_range(1, 5)) tick(1'b1);
    reset = 1'b1;
    start_btn = 1'b1;
    tick(1'b0);
    chk("abort_state", game_state, 0);
    chk("abort_level", level, 0);
    chk("abort_freeze", freeze, 1);
    chk("abort_rf", reset_frog, 0);
    chk("abort_rl", reset_lives, 0);
    chk("abort_score", score, 0);
    tick(1'b0);
    reset = 1'b0;
    repeat (4) tick(1'b0);
    chk("held_start_state", game_state, 0);
    chk("held_start_rf", reset_frog, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
